// File: rtl/posit_add_arbiter.sv
// -----------------------------------------------------------------------------
// posit_add_arbiter
//
// Shares one pipelined posit adder between NREQ requesters. A round-robin
// arbiter grants at most one valid/ready request per cycle, the granted
// operand pair is registered onto the adder inputs, and a tag pipeline that
// runs alongside the adder carries the requester ID. Each result is
// registered and strobed back to the requester that issued it.
//
// Parameters
//   WIDTH    posit width (operand/result width)
//   EN       posit exponent size; only range-checked here, used by the adder
//   NREQ     number of requesters, 2..8
//   ADD_LAT  adder latency in cycles (add_a/add_b in to add_q out), >= 1
//   IDW      requester-ID width, derived from NREQ
//
// Ports
//   clk_i            clock
//   rst_i            asynchronous reset, active-high
//   en_i             1 = new grants allowed, 0 = drain in-flight ops only
//   req_valid_i      per-requester request valid
//   req_a_i/req_b_i  packed operands; requester i owns [i*WIDTH +: WIDTH]
//   req_ready_o      one-hot grant, combinational from req_valid/en/pointer
//   add_a_o/add_b_o  registered operands to the adder
//   add_q_i          adder result
//   rsp_valid_o      one-hot, one-cycle result strobe
//   rsp_id_o         requester ID of the current/last result
//   rsp_data_o       result data, held between strobes
//   busy_o           any op in flight, a response strobing, or a grant now
//
// Optional feature (macro POSIT_ARB_PERF_EN)
//   perf_issue_o     count of transfers
//   perf_conflict_o  cycles with two or more requests while en_i = 1
//   Both reset to 0, wrap at 2^32 and update the cycle after the event.
// -----------------------------------------------------------------------------
module posit_add_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned EN      = 3,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned ADD_LAT = 2,
    localparam int unsigned IDW    = $clog2(NREQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*WIDTH-1:0] req_a_i,
    input  logic [NREQ*WIDTH-1:0] req_b_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic [WIDTH-1:0]      add_a_o,
    output logic [WIDTH-1:0]      add_b_o,
    input  logic [WIDTH-1:0]      add_q_i,
    output logic [NREQ-1:0]       rsp_valid_o,
    output logic [IDW-1:0]        rsp_id_o,
    output logic [WIDTH-1:0]      rsp_data_o,
    output logic                  busy_o
`ifdef POSIT_ARB_PERF_EN
    ,
    output logic [31:0]           perf_issue_o,
    output logic [31:0]           perf_conflict_o
`endif
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    if (NREQ < 2 || NREQ > 8) begin : g_chk_nreq
        $error("posit_add_arbiter: NREQ must be in 2..8");
    end
    if (ADD_LAT < 1) begin : g_chk_lat
        $error("posit_add_arbiter: ADD_LAT must be >= 1");
    end
    if (EN + 3 > WIDTH) begin : g_chk_en
        $error("posit_add_arbiter: EN too large for WIDTH");
    end

    // -------------------------------------------------------------------------
    // Round-robin arbiter
    // -------------------------------------------------------------------------
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_any;
    logic [IDW:0]    scan_sum;
    logic [IDW-1:0]  scan_idx;

    // Search starts at ptr+1 and wraps. scan_sum is one bit wider than the
    // ID so ptr+k (at most 2*NREQ-1) never overflows before the wrap.
    always_comb begin
        gnt      = '0;
        gnt_id   = '0;
        gnt_any  = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        if (en_i && !rst_i) begin
            for (int k = 1; k <= int'(NREQ); k++) begin
                scan_sum = {1'b0, ptr_q} + (IDW+1)'(k);
                if (scan_sum >= (IDW+1)'(NREQ)) begin
                    scan_sum = scan_sum - (IDW+1)'(NREQ);
                end
                scan_idx = scan_sum[IDW-1:0];
                if (!gnt_any && req_valid_i[scan_idx]) begin
                    gnt_any          = 1'b1;
                    gnt_id           = scan_idx;
                    gnt[scan_idx]    = 1'b1;
                end
            end
        end
    end

    assign req_ready_o = gnt;

    // A grant is only ever raised on a valid request, so grant == transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = gnt_id;
        end
    end

    // -------------------------------------------------------------------------
    // Operand issue registers
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) begin
                sel_a = req_a_i[i*WIDTH +: WIDTH];
                sel_b = req_b_i[i*WIDTH +: WIDTH];
            end
        end
    end

    // Operands hold when nothing issues; the tag pipeline marks them stale.
    always_comb begin
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        if (gnt_any) begin
            add_a_d = sel_a;
            add_b_d = sel_b;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q   <= IDW'(NREQ - 1);
            add_a_q <= '0;
            add_b_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
        end
    end

    assign add_a_o = add_a_q;
    assign add_b_o = add_b_q;

    // -------------------------------------------------------------------------
    // Tag pipeline
    // Stage 0 lines up with add_a/add_b; stages 1..ADD_LAT follow the adder,
    // so stage ADD_LAT lines up with add_q.
    // -------------------------------------------------------------------------
    logic [ADD_LAT:0] tag_vld_q;
    logic [IDW-1:0]   tag_id_q [ADD_LAT+1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_vld_q <= '0;
            for (int i = 0; i <= int'(ADD_LAT); i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            tag_vld_q   <= {tag_vld_q[ADD_LAT-1:0], gnt_any};
            tag_id_q[0] <= gnt_id;
            for (int i = 1; i <= int'(ADD_LAT); i++) begin
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response register
    // -------------------------------------------------------------------------
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    always_comb begin
        rsp_valid_d = '0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (tag_vld_q[ADD_LAT]) begin
            rsp_valid_d[tag_id_q[ADD_LAT]] = 1'b1;
            rsp_id_d                       = tag_id_q[ADD_LAT];
            rsp_data_d                     = add_q_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;

    // Includes the strobe cycle so busy falls the cycle after the last rsp.
    assign busy_o = gnt_any | (|tag_vld_q) | (|rsp_valid_q);

    // -------------------------------------------------------------------------
    // Optional performance counters
    // -------------------------------------------------------------------------
`ifdef POSIT_ARB_PERF_EN
    logic [31:0] perf_issue_q, perf_issue_d;
    logic [31:0] perf_conflict_q, perf_conflict_d;
    logic        multi_req;

    always_comb begin
        multi_req       = en_i && ($countones(req_valid_i) >= 2);
        perf_issue_d    = perf_issue_q + {31'd0, gnt_any};
        perf_conflict_d = perf_conflict_q + {31'd0, multi_req};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_issue_q    <= '0;
            perf_conflict_q <= '0;
        end else begin
            perf_issue_q    <= perf_issue_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_issue_o    = perf_issue_q;
    assign perf_conflict_o = perf_conflict_q;
`endif

endmodule

// File: tb/tb_posit_add_arbiter.sv
// -----------------------------------------------------------------------------
// tb_posit_add_arbiter
//
// Directed scenarios followed by a randomized phase. A reference model keeps
// the round-robin pointer as a plain integer and the expected responses in a
// queue stamped with their due cycle; every cycle the grant, adder operands,
// response strobe/ID/data and busy are compared against it.
// -----------------------------------------------------------------------------
module tb_posit_add_arbiter;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned EN      = 3;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned ADD_LAT = 2;
    localparam int unsigned IDW     = 2;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic                  en_i;
    logic [NREQ-1:0]       req_valid_i;
    logic [NREQ*WIDTH-1:0] req_a_i;
    logic [NREQ*WIDTH-1:0] req_b_i;
    logic [NREQ-1:0]       req_ready_o;
    logic [WIDTH-1:0]      add_a_o;
    logic [WIDTH-1:0]      add_b_o;
    logic [WIDTH-1:0]      add_q_i;
    logic [NREQ-1:0]       rsp_valid_o;
    logic [IDW-1:0]        rsp_id_o;
    logic [WIDTH-1:0]      rsp_data_o;
    logic                  busy_o;
`ifdef POSIT_ARB_PERF_EN
    logic [31:0]           perf_issue_o;
    logic [31:0]           perf_conflict_o;
`endif

    always #5 clk_i = ~clk_i;

    posit_add_arbiter #(
        .WIDTH   (WIDTH),
        .EN      (EN),
        .NREQ    (NREQ),
        .ADD_LAT (ADD_LAT)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .en_i            (en_i),
        .req_valid_i     (req_valid_i),
        .req_a_i         (req_a_i),
        .req_b_i         (req_b_i),
        .req_ready_o     (req_ready_o),
        .add_a_o         (add_a_o),
        .add_b_o         (add_b_o),
        .add_q_i         (add_q_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_id_o        (rsp_id_o),
        .rsp_data_o      (rsp_data_o),
        .busy_o          (busy_o)
`ifdef POSIT_ARB_PERF_EN
        ,
        .perf_issue_o    (perf_issue_o),
        .perf_conflict_o (perf_conflict_o)
`endif
    );

    // Stand-in for the posit adder: fixed ADD_LAT latency, and an operation
    // that maps 1.0 + 1.0 (0x40000000 each) to 0x48000000 like the real one.
    function automatic logic [WIDTH-1:0] add_fn(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        return a + (b >> 3);
    endfunction

    logic [WIDTH-1:0] adder_pipe [ADD_LAT];
    always @(posedge clk_i) begin
        adder_pipe[0] <= add_fn(add_a_o, add_b_o);
        for (int i = 1; i < int'(ADD_LAT); i++) adder_pipe[i] <= adder_pipe[i-1];
    end
    assign add_q_i = adder_pipe[ADD_LAT-1];

    // ---------------------------------------------------------------- model
    typedef struct {
        int               due;
        int               id;
        logic [WIDTH-1:0] data;
    } rsp_t;

    rsp_t             exp_q[$];
    int               m_ptr;
    int               cyc;
    int               last_gid;
    int               last_id;
    logic [WIDTH-1:0] last_data;
    logic [WIDTH-1:0] last_a;
    logic [WIDTH-1:0] last_b;
    int               m_issue;
    int               m_conflict;
    int               n_cmp;
    int               n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ptr      = int'(NREQ) - 1;
        last_id    = 0;
        last_data  = '0;
        last_a     = '0;
        last_b     = '0;
        m_issue    = 0;
        m_conflict = 0;
    endtask

    // Pulse reset asynchronously mid-cycle and check the reset state.
    task automatic do_reset();
        rst_i = 1'b1;
        #2;
        model_reset();
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_id", rsp_id_o, 0);
        chk("rst_rsp_data", rsp_data_o, 0);
        chk("rst_add_a", add_a_o, 0);
        chk("rst_add_b", add_b_o, 0);
        chk("rst_busy", busy_o, 0);
`ifdef POSIT_ARB_PERF_EN
        chk("rst_perf_issue", perf_issue_o, 0);
        chk("rst_perf_conflict", perf_conflict_o, 0);
`endif
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // One clock cycle: check everything against the model at the negedge,
    // advance the model, then step to just after the next posedge.
    task automatic cycle();
        int               gid;
        int               nvalid;
        logic [NREQ-1:0]  g_exp;
        logic [NREQ-1:0]  v_exp;
        logic             b_exp;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        @(negedge clk_i);
        gid    = -1;
        nvalid = 0;
        g_exp  = '0;
        for (int i = 0; i < int'(NREQ); i++) if (req_valid_i[i]) nvalid++;
        if (en_i) begin
            for (int k = 1; k <= int'(NREQ); k++) begin
                if (gid < 0 && req_valid_i[(m_ptr + k) % int'(NREQ)]) begin
                    gid = (m_ptr + k) % int'(NREQ);
                end
            end
        end
        if (gid >= 0) g_exp[gid] = 1'b1;
        chk("req_ready", req_ready_o, g_exp);
        chk("add_a", add_a_o, last_a);
        chk("add_b", add_b_o, last_b);

        b_exp = (gid >= 0) || (exp_q.size() > 0);
        v_exp = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            v_exp[exp_q[0].id] = 1'b1;
            last_id            = exp_q[0].id;
            last_data          = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        chk("rsp_valid", rsp_valid_o, v_exp);
        chk("rsp_id", rsp_id_o, last_id);
        chk("rsp_data", rsp_data_o, last_data);
        chk("busy", busy_o, b_exp);
`ifdef POSIT_ARB_PERF_EN
        chk("perf_issue", perf_issue_o, m_issue);
        chk("perf_conflict", perf_conflict_o, m_conflict);
`endif
        if (en_i && nvalid >= 2) m_conflict++;
        last_gid = gid;
        if (gid >= 0) begin
            a = req_a_i[gid*WIDTH +: WIDTH];
            b = req_b_i[gid*WIDTH +: WIDTH];
            exp_q.push_back('{due: cyc + int'(ADD_LAT) + 2, id: gid, data: add_fn(a, b)});
            m_ptr  = gid;
            last_a = a;
            last_b = b;
            m_issue++;
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic new_operands(input int i);
        req_a_i[i*WIDTH +: WIDTH] = $urandom;
        req_b_i[i*WIDTH +: WIDTH] = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        cyc         = 0;
        last_gid    = -1;
        en_i        = 1'b0;
        req_valid_i = '0;
        req_a_i     = '0;
        req_b_i     = '0;
        model_reset();
        do_reset();

        // Single op: 1.0 + 1.0 from requester 0.
        en_i                = 1'b1;
        req_a_i[0 +: WIDTH] = 32'h4000_0000;
        req_b_i[0 +: WIDTH] = 32'h4000_0000;
        req_valid_i         = 4'b0001;
        cycle();
        req_valid_i = '0;
        idle(6);

        // All four valid for 8 cycles: grants rotate 0,1,2,3,0,1,2,3.
        do_reset();
        en_i = 1'b1;
        for (int i = 0; i < int'(NREQ); i++) new_operands(i);
        req_valid_i = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            cycle();
            if (last_gid >= 0) new_operands(last_gid);
        end
        req_valid_i = '0;
        idle(6);
`ifdef POSIT_ARB_PERF_EN
        chk("t2_perf_issue", perf_issue_o, 8);
        chk("t2_perf_conflict", perf_conflict_o, 8);
`endif

        // Grant up to 2, then only 1 and 3 valid: expect 3, 1, 3.
        do_reset();
        en_i        = 1'b1;
        req_valid_i = 4'b1111;
        idle(3);
        req_valid_i = 4'b1010;
        for (int n = 0; n < 3; n++) begin
            cycle();
            if (last_gid >= 0) new_operands(last_gid);
        end
        req_valid_i = '0;
        idle(6);

        // en drops after two issues while requester 0 stays valid.
        req_valid_i = 4'b0001;
        for (int n = 0; n < 2; n++) begin
            cycle();
            new_operands(0);
        end
        en_i = 1'b0;
        idle(7);
        req_valid_i = '0;
        en_i        = 1'b1;

        // Reset one cycle after an issue: no response, pointer back to NREQ-1.
        req_valid_i = 4'b0100;
        cycle();
        req_valid_i = '0;
        cycle();
        do_reset();
        idle(4);
        req_valid_i = 4'b1111;
        cycle();
        req_valid_i = '0;
        idle(6);

        // Randomized traffic; a waiting requester keeps its request and data.
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (last_gid == i || !req_valid_i[i]) begin
                    new_operands(i);
                    req_valid_i[i] = ($urandom_range(0, 99) < 55);
                end
            end
            en_i = ($urandom_range(0, 9) != 0);
            cycle();
        end
        req_valid_i = '0;
        en_i        = 1'b1;
        idle(6);
        chk("final_busy", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
